// File: rtl/cdc_reset_sequencer.sv
// Ordered reset release sequencer for one clock domain.
// Holds every reset output asserted for MIN_ASSERT cycles after the domain
// reset drops, then releases the outputs one at a time (index 0 first),
// spaced by at least GAP cycles. A stage selected in ACK_MASK must also
// acknowledge before the next stage is released. A stage that never
// acknowledges within TIMEOUT cycles parks the sequencer in an error state.
//
// Acknowledge handshake: stage_ack[i] is a level, synchronous to clk. It is
// looked at only while stage i is the most recently released stage. It is
// accepted on the first edge where it is high and the GAP spacing has been
// met. An ack that is already high when stage i is released counts at once.
// Dropping the ack after that edge has no effect.
module cdc_reset_sequencer #(
  parameter int unsigned      N_RST      = 3,
  parameter int unsigned      MIN_ASSERT = 4,
  parameter int unsigned      GAP        = 2,
  parameter int unsigned      TIMEOUT    = 64,
  parameter logic [N_RST-1:0] ACK_MASK   = '0,
  localparam int unsigned     IDX_W      = (N_RST > 1) ? $clog2(N_RST) : 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             sw_rst_req,
  input  logic [N_RST-1:0] stage_ack,
  output logic [N_RST-1:0] rst_out,
  output logic             busy,
  output logic             rst_done,
  output logic             err,
  output logic [IDX_W-1:0] err_stage,
  output logic [1:0]       dbg_state
);

  // One counter serves both the assert hold and the per-stage wait, so it
  // is sized for the larger of the two limits.
  localparam int unsigned CNT_LIM = (MIN_ASSERT > TIMEOUT) ? MIN_ASSERT : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_LIM + 1);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ASSERT_END = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] TMO_END    = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_RST - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_RST-1:0]   rst_out_q, rst_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   err_stage_q, err_stage_d;

  logic               ack_ok;
  logic [IDX_W-1:0]   idx_nxt;
  logic [CNT_W-1:0]   cnt_inc;

  // Current stage may advance: either it does not wait for an ack, or the
  // ack is present this cycle.
  always_comb begin
    ack_ok  = !ACK_MASK[idx_q] || stage_ack[idx_q];
    idx_nxt = idx_q + 1'b1;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state and next-output decode; a software request restarts from
  // ASSERT regardless of where the sequence is.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_out_d   = rst_out_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;

    if (sw_rst_req) begin
      state_d     = ST_ASSERT;
      cnt_d       = '0;
      idx_d       = '0;
      rst_out_d   = '1;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_stage_d = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          // The edge that completes the hold also releases stage 0, so the
          // outputs are all-asserted for exactly MIN_ASSERT cycles.
          if (cnt_q == ASSERT_END) begin
            state_d      = ST_RELEASE;
            cnt_d        = '0;
            idx_d        = '0;
            rst_out_d    = '1;
            rst_out_d[0] = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_RELEASE: begin
          // cnt holds the number of edges since stage idx was released.
          if ((cnt_q >= GAP_END) && ack_ok) begin
            if (idx_q != LAST_IDX) begin
              idx_d     = idx_nxt;
              cnt_d     = '0;
              rst_out_d = rst_out_q & ~(N_RST'(1) << idx_nxt);
            end else begin
              state_d   = ST_DONE;
              rst_out_d = '0;
              busy_d    = 1'b0;
              done_d    = 1'b1;
            end
          end else if (!ack_ok && (cnt_q == TMO_END)) begin
            // Released stages stay released; later stages stay in reset.
            state_d     = ST_ERROR;
            busy_d      = 1'b0;
            err_d       = 1'b1;
            err_stage_d = idx_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        ST_ERROR: begin
          state_d = ST_ERROR;
        end

        default: begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; srst wins over everything else.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign busy      = busy_q;
  assign rst_done  = done_q;
  assign err       = err_q;
  assign err_stage = err_stage_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cdc_reset_sequencer.sv
// Directed bench for cdc_reset_sequencer. Three instances share clk, srst
// and sw_rst_req: dut_a (no ack waits), dut_b (stages 0 and 1 wait for an
// ack) and dut_c (single stage, short limits). Inputs change 1ns after the
// rising edge; outputs are compared at the same point, after they settle.
`timescale 1ns/1ps
module tb_cdc_reset_sequencer;

  // Clock and shared controls
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst;
  logic       sw_rst_req;

  logic [2:0] ack_a, ack_b;
  logic [0:0] ack_c;

  logic [2:0] rst_a, rst_b;
  logic [0:0] rst_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       err_a, err_b, err_c;
  logic [1:0] es_a, es_b;
  logic [0:0] es_c;
  logic [1:0] st_a, st_b, st_c;

  int  vectors;
  int  miscompares;
  bit  chk_en;

  cdc_reset_sequencer #(
    .N_RST(3), .MIN_ASSERT(4), .GAP(2), .TIMEOUT(64), .ACK_MASK(3'b000)
  ) dut_a (
    .clk(clk), .srst(srst), .sw_rst_req(sw_rst_req), .stage_ack(ack_a),
    .rst_out(rst_a), .busy(busy_a), .rst_done(done_a), .err(err_a),
    .err_stage(es_a), .dbg_state(st_a)
  );

  cdc_reset_sequencer #(
    .N_RST(3), .MIN_ASSERT(4), .GAP(2), .TIMEOUT(64), .ACK_MASK(3'b011)
  ) dut_b (
    .clk(clk), .srst(srst), .sw_rst_req(sw_rst_req), .stage_ack(ack_b),
    .rst_out(rst_b), .busy(busy_b), .rst_done(done_b), .err(err_b),
    .err_stage(es_b), .dbg_state(st_b)
  );

  cdc_reset_sequencer #(
    .N_RST(1), .MIN_ASSERT(1), .GAP(2), .TIMEOUT(5), .ACK_MASK(1'b1)
  ) dut_c (
    .clk(clk), .srst(srst), .sw_rst_req(sw_rst_req), .stage_ack(ack_c),
    .rst_out(rst_c), .busy(busy_c), .rst_done(done_c), .err(err_c),
    .err_stage(es_c), .dbg_state(st_c)
  );

  // Released stages must always form a contiguous run starting at bit 0.
  function automatic bit ordered3(input logic [2:0] r);
    logic [2:0] m;
    m = ~r;
    return ((m & (m + 3'd1)) == 3'd0) && !$isunknown(r);
  endfunction

  // Driver: advance one edge, then check the ordering invariant.
  task automatic step();
    @(posedge clk);
    #1;
    if (chk_en) begin
      vectors++;
      if (!ordered3(rst_a) || !ordered3(rst_b)) begin
        miscompares++;
        $display("FAIL order_invariant got rst_a=%b rst_b=%b want contiguous released run", rst_a, rst_b);
      end
    end
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1; sw_rst_req = 1'b0;
    ack_a = '0; ack_b = '0; ack_c = '0;
    repeat (5) step();
    chk_en = 1'b1;
    vectors++;
    if ({rst_a, busy_a, done_a, err_a, es_a, st_a} !== {3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_a got %b want %b", {rst_a, busy_a, done_a, err_a, es_a, st_a}, 9'b111100000);
    end
    vectors++;
    if ({rst_b, busy_b, done_b, err_b, es_b, st_b} !== {3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_b got %b want %b", {rst_b, busy_b, done_b, err_b, es_b, st_b}, 9'b111100000);
    end
    vectors++;
    if ({rst_c, busy_c, done_c, err_c, es_c, st_c} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_c got %b want %b", {rst_c, busy_c, done_c, err_c, es_c, st_c}, 7'b1100000);
    end
  endtask

  // First edge with srst low is k=0; falls at k=3,5,7, done at k=9.
  task automatic test_power_up();
    logic [2:0] tbl [10];
    logic       exp_done;
    tbl = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
    srst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      exp_done = (k == 9);
      vectors++;
      if ({rst_a, busy_a, done_a, err_a} !== {tbl[k], !exp_done, exp_done, 1'b0}) begin
        miscompares++;
        $display("FAIL power_up k=%0d got %b want %b", k, {rst_a, busy_a, done_a, err_a}, {tbl[k], !exp_done, exp_done, 1'b0});
      end
    end
  endtask

  // Stage 1 ack raised 10 cycles after its fall (k=16); stage 2 falls at k=17.
  task automatic test_ack_wait();
    logic [2:0] exp_r;
    ack_b = 3'b001;
    pulse_sw();
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_r = {(k < 17), (k < 6), (k < 4)};
      vectors++;
      if ({rst_b, done_b, err_b} !== {exp_r, (k >= 19), 1'b0}) begin
        miscompares++;
        $display("FAIL ack_wait k=%0d got %b want %b", k, {rst_b, done_b, err_b}, {exp_r, (k >= 19), 1'b0});
      end
      if (k == 16) ack_b = 3'b011;
    end
  endtask

  // Stage 0 falls at k=4 and never acks: error exactly 64 cycles later.
  task automatic test_timeout();
    ack_b = 3'b000;
    pulse_sw();
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 4 || k == 67) begin
        vectors++;
        if ({rst_b, busy_b, err_b} !== {3'b110, 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL timeout_pre k=%0d got %b want %b", k, {rst_b, busy_b, err_b}, 5'b11010);
        end
      end
      if (k == 68 || k == 70) begin
        vectors++;
        if ({rst_b, busy_b, done_b, err_b, es_b} !== {3'b110, 1'b0, 1'b0, 1'b1, 2'd0}) begin
          miscompares++;
          $display("FAIL timeout_err k=%0d got %b want %b", k, {rst_b, busy_b, done_b, err_b, es_b}, 8'b11000100);
        end
      end
    end
    ack_b = 3'b111;
    pulse_sw();
    vectors++;
    if ({rst_b, busy_b, done_b, err_b} !== {3'b111, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_clear got %b want %b", {rst_b, busy_b, done_b, err_b}, 6'b111100);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9 || k == 10) begin
        vectors++;
        if ({rst_b, busy_b, done_b, err_b} !== {3'b000, (k != 10), (k == 10), 1'b0}) begin
          miscompares++;
          $display("FAIL timeout_rerun k=%0d got %b want %b", k, {rst_b, busy_b, done_b, err_b}, {3'b000, (k != 10), (k == 10), 1'b0});
        end
      end
    end
  endtask

  // Restart while rst_a=100, then the whole sequence repeats with same timing.
  task automatic test_sw_restart();
    logic [2:0] exp_r;
    pulse_sw();
    repeat (6) step();
    vectors++;
    if (rst_a !== 3'b100) begin
      miscompares++;
      $display("FAIL restart_pre got %b want %b", rst_a, 3'b100);
    end
    pulse_sw();
    vectors++;
    if ({rst_a, busy_a, done_a} !== {3'b111, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL restart_now got %b want %b", {rst_a, busy_a, done_a}, 5'b11110);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_r = {(k < 8), (k < 6), (k < 4)};
      vectors++;
      if ({rst_a, busy_a, done_a} !== {exp_r, (k < 10), (k == 10)}) begin
        miscompares++;
        $display("FAIL restart_seq k=%0d got %b want %b", k, {rst_a, busy_a, done_a}, {exp_r, (k < 10), (k == 10)});
      end
    end
  endtask

  // Three consecutive requests: the hold restarts each time.
  task automatic test_back_to_back();
    sw_rst_req = 1'b1;
    repeat (3) step();
    sw_rst_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (rst_a !== ((k < 4) ? 3'b111 : 3'b110)) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d got %b want %b", k, rst_a, (k < 4) ? 3'b111 : 3'b110);
      end
    end
  endtask

  // srst together with sw_rst_req, once mid-sequence and once in ERROR.
  task automatic test_srst_override();
    ack_b = 3'b000;
    pulse_sw();
    repeat (5) step();
    vectors++;
    if (rst_a !== 3'b110) begin
      miscompares++;
      $display("FAIL override_pre got %b want %b", rst_a, 3'b110);
    end
    srst = 1'b1; sw_rst_req = 1'b1;
    step();
    vectors++;
    if ({rst_a, busy_a, done_a, err_a, es_a, st_a} !== {3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL override_mid got %b want %b", {rst_a, busy_a, done_a, err_a, es_a, st_a}, 9'b111100000);
    end
    srst = 1'b0; sw_rst_req = 1'b0;
    repeat (68) step();
    vectors++;
    if ({err_b, st_b} !== {1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL override_err_pre got %b want %b", {err_b, st_b}, 3'b111);
    end
    srst = 1'b1; sw_rst_req = 1'b1;
    step();
    vectors++;
    if ({rst_b, busy_b, done_b, err_b, es_b, st_b} !== {3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL override_err got %b want %b", {rst_b, busy_b, done_b, err_b, es_b, st_b}, 9'b111100000);
    end
    srst = 1'b0; sw_rst_req = 1'b0;
  endtask

  // N_RST=1, MIN_ASSERT=1, TIMEOUT=5: fall one edge after request.
  task automatic test_single_stage();
    ack_c = 1'b0;
    pulse_sw();
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1 || k == 5) begin
        vectors++;
        if ({rst_c, busy_c, err_c} !== 3'b010) begin
          miscompares++;
          $display("FAIL single_wait k=%0d got %b want %b", k, {rst_c, busy_c, err_c}, 3'b010);
        end
      end
    end
    vectors++;
    if ({rst_c, busy_c, done_c, err_c, es_c} !== 5'b00010) begin
      miscompares++;
      $display("FAIL single_err got %b want %b", {rst_c, busy_c, done_c, err_c, es_c}, 5'b00010);
    end
    ack_c = 1'b1;
    pulse_sw();
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++;
      if ({rst_c, busy_c, done_c, err_c} !== {1'b0, (k < 3), (k == 3), 1'b0}) begin
        miscompares++;
        $display("FAIL single_done k=%0d got %b want %b", k, {rst_c, busy_c, done_c, err_c}, {1'b0, (k < 3), (k == 3), 1'b0});
      end
    end
  endtask

  // Random srst hold/gap and ack delays e (ack first sampled at fall+e).
  task automatic test_random();
    int h, gap, e0, e1, f0, f1, f2, t_err, t_done, es_exp;
    logic [2:0] exp_r;
    logic       exp_err, exp_done;
    for (int it = 0; it < 10; it++) begin
      h   = $urandom_range(1, 4);
      gap = $urandom_range(50, 150);
      e0  = int'($urandom_range(0, 73)) - 3;
      e1  = int'($urandom_range(0, 73)) - 3;
      if (it == 0) begin e0 = 64; e1 = 65; gap = 150; end
      f0 = 3; f1 = 1000000; f2 = 1000000; t_err = 1000000; t_done = 1000000; es_exp = 0;
      if (e0 <= 64) f1 = f0 + ((e0 > 2) ? e0 : 2);
      else t_err = f0 + 64;
      if (f1 < 1000000) begin
        if (e1 <= 64) f2 = f1 + ((e1 > 2) ? e1 : 2);
        else begin t_err = f1 + 64; es_exp = 1; end
      end
      if (f2 < 1000000) t_done = f2 + 2;

      srst = 1'b1; ack_b = '0;
      repeat (h) begin
        ack_a = 3'($urandom);
        step();
      end
      vectors++;
      if ({rst_b, busy_b, done_b, err_b} !== 6'b111100) begin
        miscompares++;
        $display("FAIL rand_reset it=%0d got %b want %b", it, {rst_b, busy_b, done_b, err_b}, 6'b111100);
      end
      srst = 1'b0;
      for (int k = -1; k < gap; k++) begin
        if (k >= 0) begin
          step();
          exp_r    = {(k < f2), (k < f1), (k < f0)};
          exp_err  = (k >= t_err);
          exp_done = (k >= t_done);
          vectors++;
          if ({rst_b, busy_b, done_b, err_b} !== {exp_r, !exp_err && !exp_done, exp_done, exp_err} ||
              (exp_err && es_b !== 2'(es_exp))) begin
            miscompares++;
            $display("FAIL rand_b it=%0d k=%0d got %b es=%0d want %b es=%0d", it, k,
                     {rst_b, busy_b, done_b, err_b}, es_b, {exp_r, !exp_err && !exp_done, exp_done, exp_err}, es_exp);
          end
          vectors++;
          if ({rst_a, done_a} !== {(k < 7), (k < 5), (k < 3), (k >= 9)}) begin
            miscompares++;
            $display("FAIL rand_a it=%0d k=%0d got %b want %b", it, k, {rst_a, done_a}, {(k < 7), (k < 5), (k < 3), (k >= 9)});
          end
        end
        ack_a    = 3'($urandom);
        ack_b[0] = (k >= f0 + e0 - 1) && (k < f1);
        ack_b[1] = (k >= f1 + e1 - 1) && (k < f2);
        ack_b[2] = 1'($urandom);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    chk_en = 1'b0;
    test_reset();
    test_power_up();
    test_ack_wait();
    test_timeout();
    test_sw_restart();
    test_back_to_back();
    test_srst_override();
    test_single_stage();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
